// File: rtl/imem_loader_if.sv
// Boot-loader bus: byte stream from the host plus the instruction-RAM write port.
// master = host/debug side (sources bytes, observes writes); slave = the loader.
interface imem_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory boot loader: packs big-endian byte pairs into 16-bit words,
// writes them from address 0 and releases the CPU once the halt word lands.
module imem_loader #(
    parameter int SIZE = 200
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    imem_loader_if.slave bus,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_err,
    output logic [15:0]  o_word_count,
    output logic         o_cpu_hold
);
    localparam logic [15:0] SIZE_W = 16'(SIZE);
    localparam logic [15:0] HALT_W = 16'hFFFF;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI    = 3'd1,
        LO    = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        ERR   = 3'd5
    } state_t;

    state_t      r_state;
    logic [15:0] r_addr;
    logic [7:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_in_ready;
    logic        r_wr_en;
    logic [15:0] r_wr_addr;
    logic [15:0] r_wr_data;
    logic        r_busy;
    logic        r_done;
    logic        r_err;
    logic [15:0] r_word_count;
    logic        r_cpu_hold;
    logic        w_accept;

    assign w_accept = bus.in_valid && r_in_ready;

    // Loader FSM; every output is set one cycle ahead alongside its state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= IDLE;
            r_addr       <= 16'd0;
            r_hi         <= 8'd0;
            r_lo         <= 8'd0;
            r_in_ready   <= 1'b0;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= 16'd0;
            r_wr_data    <= 16'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_word_count <= 16'd0;
            r_cpu_hold   <= 1'b1;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                IDLE, DONE, ERR: begin
                    if (i_start) begin
                        r_state      <= HI;
                        r_addr       <= 16'd0;
                        r_word_count <= 16'd0;
                        r_in_ready   <= 1'b1;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
                        r_err        <= 1'b0;
                        r_cpu_hold   <= 1'b1;
                    end else begin
                        r_state <= r_state;
                    end
                end
                HI: begin
                    if (w_accept) begin
                        r_hi    <= bus.in_data;
                        r_state <= LO;
                    end else begin
                        r_state <= HI;
                    end
                end
                LO: begin
                    if (w_accept) begin
                        r_lo       <= bus.in_data;
                        r_state    <= WRITE;
                        r_in_ready <= 1'b0;
                        r_wr_en    <= 1'b1;
                        r_wr_addr  <= r_addr;
                        r_wr_data  <= {r_hi, bus.in_data};
                    end else begin
                        r_state <= LO;
                    end
                end
                WRITE: begin
                    r_word_count <= r_word_count + 16'd1;
                    // The halt word is stored too, and wins over a full memory.
                    if ({r_hi, r_lo} == HALT_W) begin
                        r_state    <= DONE;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_cpu_hold <= 1'b0;
                    end else if (r_addr + 16'd1 == SIZE_W) begin
                        r_state <= ERR;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_addr     <= r_addr + 16'd1;
                        r_state    <= HI;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_in_ready <= 1'b0;
                    r_busy     <= 1'b0;
                    r_done     <= 1'b0;
                    r_err      <= 1'b0;
                    r_cpu_hold <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_err         = r_err;
    assign o_word_count  = r_word_count;
    assign o_cpu_hold    = r_cpu_hold;
endmodule
